// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the FSM state enum, frame-format encodings and frame length math.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    localparam int FRAME_BITS_W = 4;

    // Mode 2'b11 is an alias for no parity.
    function automatic logic parity_en(input logic [1:0] pmode);
        return (pmode == PAR_EVEN) || (pmode == PAR_ODD);
    endfunction

    // Total bits per frame: start + data + optional parity + 1 or 2 stops.
    function automatic logic [FRAME_BITS_W-1:0] frame_bits(
        input logic [1:0] dbits,
        input logic [1:0] pmode,
        input logic       stop2
    );
        return 4'd7 + {2'b00, dbits} + {3'b000, parity_en(pmode)} + {3'b000, stop2};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy; push while full and pop while
// empty are ignored. Head word is presented combinationally on o_rdata.
module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with TX FIFO and per-frame latched format/baud settings.
// txd and tx_done are registered one cycle behind the FSM state.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | line idle; pop FIFO head and latch config when non-empty
// ST_START  | start bit (0)
// ST_DATA   | data bits, LSB first, data_bits+5 of them
// ST_PARITY | even/odd parity bit over the sent data bits
// ST_STOP   | 1 or 2 stop bits; may pop straight into ST_START
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       parity_mode,
    input  logic             stop2,
    output logic             txd,
    output logic             busy,
    output logic             tx_done
);

    tx_state_t               r_state;
    tx_state_t               w_state_nxt;
    logic [DIV_W-1:0]        r_timer;
    logic [DIV_W-1:0]        r_div;
    logic [1:0]              r_dbits;
    logic [1:0]              r_pmode;
    logic                    r_stop2;
    logic [7:0]              r_shift;
    logic [2:0]              r_bit_idx;
    logic [FRAME_BITS_W-1:0] r_bits_left;
    logic                    r_par;
    logic                    r_txd;
    logic                    r_tx_done;
    logic                    r_overflow;

    logic                    w_bit_end;
    logic                    w_last_data;
    logic                    w_pop;
    logic                    w_frame_end;
    logic                    w_txd_bit;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [7:0]              w_fifo_rdata;
    logic [CNT_W-1:0]        w_fifo_count;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr_en),
        .i_pop   (w_pop),
        .i_wdata (wr_data),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_bit_end   = (r_timer == '0);
    assign w_last_data = (r_bit_idx == ({1'b0, r_dbits} + 3'd4));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_frame_end = 1'b0;
        w_txd_bit   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_txd_bit = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_txd_bit = r_shift[0];
                if (w_bit_end && w_last_data) begin
                    w_state_nxt = parity_en(r_pmode) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                w_txd_bit = r_par ^ (r_pmode == PAR_ODD);
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // r_bits_left reaches zero only during the final stop bit.
                if (w_bit_end && (r_bits_left == '0)) begin
                    w_frame_end = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Config is sampled from the live inputs on every pop, so a change made
    // mid-frame applies from the next start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= '0;
            r_div       <= '0;
            r_dbits     <= DBITS_8;
            r_pmode     <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_bits_left <= '0;
            r_par       <= 1'b0;
        end else if (w_pop) begin
            r_timer     <= baud_div;
            r_div       <= baud_div;
            r_dbits     <= data_bits;
            r_pmode     <= parity_mode;
            r_stop2     <= stop2;
            r_shift     <= w_fifo_rdata;
            r_bit_idx   <= '0;
            r_bits_left <= frame_bits(data_bits, parity_mode, stop2) - 4'd1;
            r_par       <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            if (w_bit_end) begin
                r_timer     <= r_div;
                r_bits_left <= r_bits_left - 4'd1;
                if (r_state == ST_DATA) begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_par     <= r_par ^ r_shift[0];
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_timer <= r_timer - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd      <= 1'b1;
            r_tx_done  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_txd     <= w_txd_bit;
            r_tx_done <= w_frame_end;
            if (wr_en && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign txd        = r_txd;
    assign tx_done    = r_tx_done;
    assign busy       = (r_state != ST_IDLE);
    assign full       = w_fifo_full;
    assign overflow   = r_overflow;
    assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param: frame formats, FIFO
// full/overflow, back-to-back frames, mid-frame config change and reset.
module tb_uart_tx_param;

    localparam int TR_LEN = 1024;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        overflow;
    logic [2:0]  fifo_count;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic        txd;
    logic        busy;
    logic        tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tr_txd  [TR_LEN];
    logic       tr_busy [TR_LEN];
    logic       tr_done [TR_LEN];
    logic [2:0] tr_cnt  [TR_LEN];
    int         tr_idx;

    int exp_cnt  [6] = '{1, 1, 2, 3, 4, 4};
    int exp_full [6] = '{0, 0, 0, 0, 1, 1};
    int exp_ovf  [6] = '{0, 0, 0, 0, 0, 1};

    uart_tx_param #(
        .DIV_W      (16),
        .FIFO_DEPTH (4),
        .CNT_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .overflow    (overflow),
        .fifo_count  (fifo_count),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .txd         (txd),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec();
        if (tr_idx < TR_LEN) begin
            tr_txd[tr_idx]  = txd;
            tr_busy[tr_idx] = busy;
            tr_done[tr_idx] = tx_done;
            tr_cnt[tr_idx]  = fifo_count;
        end
        tr_idx++;
    endtask

    // One write, then record ncyc samples; index 0 is just after the write edge.
    task automatic single_frame(input logic [7:0] data, input int ncyc);
        tr_idx  = 0;
        wr_data = data;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rec();
        for (int i = 1; i < ncyc; i++) begin
            tick();
            rec();
        end
    endtask

    // exp holds the line bits in transmit order, bit 0 = start bit.
    task automatic chk_frame(input string tag, input int s, input int p, input int nb,
                             input logic [11:0] exp);
        logic [11:0] obs;
        int          glitch;
        int          ndone;
        obs    = '0;
        glitch = 0;
        ndone  = 0;
        for (int i = 0; i < nb; i++) begin
            obs[i] = tr_txd[s + i*p + p/2];
            for (int c = 0; c < p; c++) begin
                if (tr_txd[s + i*p + c] !== exp[i]) glitch++;
            end
        end
        for (int c = s; c < s + nb*p; c++) begin
            if (tr_done[c] === 1'b1) ndone++;
        end
        chk({tag, ".line_before_start"}, 32'(tr_txd[s-1]), 32'd1);
        chk({tag, ".bits"}, 32'(obs), 32'(exp));
        chk({tag, ".bad_cycles"}, glitch, 0);
        chk({tag, ".done_count"}, ndone, 1);
        chk({tag, ".done_last"}, 32'(tr_done[s + nb*p - 1]), 32'd1);
    endtask

    initial begin
        int nbusy;
        int nlow;
        int ndone;

        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        baud_div    = 16'd3;
        data_bits   = 2'd3;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        tr_idx      = 0;
        repeat (3) tick();
        chk("rst.txd", 32'(txd), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.tx_done", 32'(tx_done), 32'd0);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        tick();

        // 8N1, 0x55: 0 | 1 0 1 0 1 0 1 0 | 1
        single_frame(8'h55, 60);
        chk("8n1.count_after_write", 32'(tr_cnt[0]), 32'd1);
        chk("8n1.busy_at_write", 32'(tr_busy[0]), 32'd0);
        chk("8n1.busy_at_pop", 32'(tr_busy[1]), 32'd1);
        chk("8n1.txd_at_pop", 32'(tr_txd[1]), 32'd1);
        nbusy = 0;
        for (int i = 0; i < 60; i++) if (tr_busy[i] === 1'b1) nbusy++;
        chk("8n1.busy_cycles", nbusy, 40);
        chk("8n1.busy_after", 32'(tr_busy[41]), 32'd0);
        chk_frame("8n1", 2, 4, 10, 12'h2AA);

        // 7E2, 0x93 -> 0x13: 0 | 1 1 0 0 1 0 0 | p=1 | 1 1
        data_bits   = 2'd2;
        parity_mode = 2'b01;
        stop2       = 1'b1;
        single_frame(8'h93, 60);
        chk_frame("7e2", 2, 4, 11, 12'h726);

        // 5O1, 0x1F: 0 | 1 1 1 1 1 | p=0 | 1
        data_bits   = 2'd0;
        parity_mode = 2'b10;
        stop2       = 1'b0;
        single_frame(8'h1F, 40);
        chk_frame("5o1_1f", 2, 4, 8, 12'h0BE);
        // 5O1, 0x0E: 0 | 0 1 1 1 0 | p=0 | 1
        single_frame(8'h0E, 40);
        chk_frame("5o1_0e", 2, 4, 8, 12'h09C);

        // FIFO full/overflow with 6 consecutive writes, 10-cycle bits, 8N1.
        baud_div    = 16'd9;
        data_bits   = 2'd3;
        parity_mode = 2'b00;
        tr_idx      = 0;
        for (int k = 0; k < 6; k++) begin
            wr_data = 8'(k + 1);
            wr_en   = 1'b1;
            tick();
            rec();
            chk($sformatf("fifo.count_w%0d", k + 1), 32'(fifo_count), exp_cnt[k]);
            chk($sformatf("fifo.full_w%0d", k + 1), 32'(full), exp_full[k]);
            chk($sformatf("fifo.ovf_w%0d", k + 1), 32'(overflow), exp_ovf[k]);
        end
        wr_en = 1'b0;
        for (int i = 6; i < 540; i++) begin
            tick();
            rec();
        end
        for (int j = 0; j < 5; j++) begin
            chk_frame($sformatf("b2b_f%0d", j + 1), 2 + 100*j, 10, 10,
                      12'h200 | (12'(j + 1) << 1));
        end
        ndone = 0;
        nlow  = 0;
        for (int i = 0; i < 540; i++) if (tr_done[i] === 1'b1) ndone++;
        for (int i = 502; i < 540; i++) if (tr_txd[i] !== 1'b1) nlow++;
        chk("b2b.done_total", ndone, 5);
        chk("b2b.txd_low_after", nlow, 0);
        chk("b2b.busy_after", 32'(tr_busy[530]), 32'd0);

        // Baud change 3 -> 7 during frame A's data bits; frame B uses 8-cycle bits.
        baud_div = 16'd3;
        tr_idx   = 0;
        wr_data  = 8'hA5;
        wr_en    = 1'b1;
        tick();
        rec();
        wr_data = 8'h3C;
        tick();
        rec();
        wr_en = 1'b0;
        for (int i = 2; i < 140; i++) begin
            if (i == 15) baud_div = 16'd7;
            tick();
            rec();
        end
        chk("cfg.count_push_pop", 32'(tr_cnt[1]), 32'd1);
        chk_frame("cfg_a", 2, 4, 10, 12'h34A);
        chk_frame("cfg_b", 42, 8, 10, 12'h278);

        // Reset mid-frame with two characters queued.
        baud_div = 16'd3;
        chk("rstmid.ovf_before", 32'(overflow), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wr_data = 8'(8'h11 * (k + 1));
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        repeat (12) tick();
        chk("rstmid.busy_before", 32'(busy), 32'd1);
        chk("rstmid.count_before", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        tick();
        chk("rstmid.txd", 32'(txd), 32'd1);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.count", 32'(fifo_count), 32'd0);
        chk("rstmid.overflow", 32'(overflow), 32'd0);
        chk("rstmid.tx_done", 32'(tx_done), 32'd0);
        chk("rstmid.full", 32'(full), 32'd0);
        rst   = 1'b0;
        nbusy = 0;
        nlow  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (busy !== 1'b0) nbusy++;
            if (txd !== 1'b1) nlow++;
        end
        chk("rstmid.busy_after", nbusy, 0);
        chk("rstmid.txd_low_after", nlow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
